// File: rtl/systolic_gen_pkg.sv
// systolic_pkg: shared FSM encoding and derived-width helpers for systolic_gen
package systolic_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int kw_f(input int max_k);
    return clog2(max_k + 1);
  endfunction
  function automatic int acc_w_f(input int dw, input int max_k);
    return 2 * dw + clog2(max_k);
  endfunction
  function automatic int idx_w_f(input int n);
    return n > 1 ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/systolic_gen_pe.sv
// systolic_pe: one output-stationary MAC cell with registered data/weight pass-through
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          sm,
  input  logic [DW-1:0] d_in,
  input  logic [DW-1:0] w_in,
  output logic [DW-1:0] d_out,
  output logic [DW-1:0] w_out,
  output logic [AW-1:0] acc
);
  logic signed [2*DW+1:0] dx, wx, prod;
  logic [AW-1:0] pext;
  assign dx = {{(DW + 2){sm & d_in[DW-1]}}, d_in};
  assign wx = {{(DW + 2){sm & w_in[DW-1]}}, w_in};
  assign prod = dx * wx;
  assign pext = AW'(prod);
  // forward operands to neighbours and accumulate while the array is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out <= '0;
      w_out <= '0;
      acc   <= '0;
    end else begin
      if (en) begin
        d_out <= d_in;
        w_out <= w_in;
      end
      acc <= clr ? '0 : en ? acc + pext : acc;
    end
  end
endmodule

// File: rtl/systolic_gen.sv
// systolic_gen: output-stationary systolic matmul tile engine; define SYSTOLIC_GEN_SAT_EN to saturate results to OUT_WIDTH
module systolic_gen
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_K      = 256,
  parameter int KW         = kw_f(MAX_K),
  parameter int ACC_WIDTH  = acc_w_f(DATA_WIDTH, MAX_K),
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH + 5,
  parameter int IW         = idx_w_f(ARRAY_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [KW-1:0]                   k_len,
  input  logic                            signed_mode,
  input  logic                            acc_keep,
  output logic                            busy,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] d_col,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_row,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IW-1:0]                   out_row_idx,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0] out_row,
  output logic                            done
);
  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int FW = clog2(2 * ARRAY_SIZE);

  if (OUT_WIDTH > ACC_WIDTH) begin : g_width_check
    $error("OUT_WIDTH must not exceed ACC_WIDTH");
  end

  state_t        state;
  logic [KW-1:0] k_q, beat_cnt;
  logic [FW-1:0] fl_cnt;
  logic          sm_q, run, hs_in, clr;
  logic [DW-1:0] dg [N][N+1];
  logic [DW-1:0] wg [N+1][N];
  logic [DW-1:0] d_unused [N];
  logic [DW-1:0] w_unused [N];
  logic [AW-1:0] acc [N][N];
  logic [N*AW-1:0] rows [N];

  assign busy     = state != IDLE;
  assign in_ready = state == FEED;
  assign hs_in    = in_valid & in_ready;
  assign run      = state == FEED || state == FLUSH;
  assign clr      = state == IDLE && start && !acc_keep;

  // tile sequencing: count accepted beats, then a fixed flush to empty the wavefront
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k_q      <= '0;
      beat_cnt <= '0;
      fl_cnt   <= '0;
      sm_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          k_q      <= k_len;
          sm_q     <= signed_mode;
          beat_cnt <= '0;
          fl_cnt   <= '0;
          state    <= k_len == '0 ? FLUSH : FEED;
        end
        FEED: if (hs_in) begin
          beat_cnt <= beat_cnt + KW'(1);
          if (beat_cnt == k_q - KW'(1)) state <= FLUSH;
        end
        FLUSH: begin
          fl_cnt <= fl_cnt + FW'(1);
          if (fl_cnt == FW'(2 * N - 2)) state <= DRAIN;
        end
        default: if (out_valid && out_ready && out_row_idx == IW'(N - 1)) state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] d_in, w_in;
    assign d_in = hs_in ? d_col[i*DW +: DW] : '0;
    assign w_in = hs_in ? w_row[i*DW +: DW] : '0;
    if (i == 0) begin : g_direct
      assign dg[0][0] = d_in;
      assign wg[0][0] = w_in;
    end else begin : g_skew
      logic [DW-1:0] ds [i];
      logic [DW-1:0] ws [i];
      // delay lane i by i cycles so row i and column i meet their partners on the same wavefront
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < i; k++) begin
            ds[k] <= '0;
            ws[k] <= '0;
          end
        end else if (run) begin
          ds[0] <= d_in;
          ws[0] <= w_in;
          for (int k = 1; k < i; k++) begin
            ds[k] <= ds[k-1];
            ws[k] <= ws[k-1];
          end
        end
      end
      assign dg[i][0] = ds[i-1];
      assign wg[0][i] = ws[i-1];
    end
    assign d_unused[i] = dg[i][N];
    assign w_unused[i] = wg[N][i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .clr   (clr),
        .sm    (sm_q),
        .d_in  (dg[i][j]),
        .w_in  (wg[i][j]),
        .d_out (dg[i][j+1]),
        .w_out (wg[i+1][j]),
        .acc   (acc[i][j])
      );
    end
  end

`ifdef SYSTOLIC_GEN_SAT_EN
  localparam logic [AW-1:0] SMAX = AW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic [AW-1:0] SMIN = AW'(-(64'sd1 <<< (OUT_WIDTH - 1)));
  localparam logic [AW-1:0] UMAX = AW'((64'sd1 <<< OUT_WIDTH) - 64'sd1);
  function automatic logic [AW-1:0] clamp(input logic [AW-1:0] a, input logic sm);
    return sm ? ($signed(a) > $signed(SMAX) ? SMAX : $signed(a) < $signed(SMIN) ? SMIN : a)
              : (a > UMAX ? UMAX : a);
  endfunction
`endif

  // present each accumulator row in output format
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rows[i] = '0;
      for (int j = 0; j < N; j++) begin
`ifdef SYSTOLIC_GEN_SAT_EN
        rows[i][j*AW +: AW] = clamp(acc[i][j], sm_q);
`else
        rows[i][j*AW +: AW] = acc[i][j];
`endif
      end
    end
  end

  // drain rows through a holding register so the presented row stays stable under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_row_idx <= '0;
      out_row     <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == DRAIN && !out_valid) begin
        out_valid <= 1'b1;
        out_row   <= rows[0];
      end else if (state == DRAIN && out_ready) begin
        if (out_row_idx == IW'(N - 1)) begin
          out_valid   <= 1'b0;
          out_row_idx <= '0;
          done        <= 1'b1;
        end else begin
          out_row_idx <= out_row_idx + IW'(1);
          out_row     <= rows[out_row_idx + IW'(1)];
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_gen.sv
// tb_systolic_gen: randomized scoreboard bench for systolic_gen against a matrix-product model
module tb_systolic_gen;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXK = 256;
  localparam int KW   = $clog2(MAXK + 1);
  localparam int ACC  = 2 * DW + $clog2(MAXK);
  localparam int OW   = 2 * DW + 5;
  localparam int IW   = $clog2(N);
  localparam longint MASK = (longint'(1) << ACC) - 1;

  logic clk = 0, rst_n = 0, start = 0, signed_mode = 0, acc_keep = 0;
  logic in_valid = 0, out_ready = 1;
  logic [KW-1:0] k_len = '0;
  logic [N*DW-1:0] d_col = '0, w_row = '0;
  logic busy, in_ready, out_valid, done;
  logic [IW-1:0] out_row_idx;
  logic [N*ACC-1:0] out_row;

  systolic_gen #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .MAX_K(MAXK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .acc_keep(acc_keep), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .d_col(d_col), .w_row(w_row), .out_valid(out_valid), .out_ready(out_ready),
    .out_row_idx(out_row_idx), .out_row(out_row), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0]    idx;
    logic [N*ACC-1:0] row;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, failures = 0, done_cnt = 0;
  bit [DW-1:0] A [N][MAXK];
  bit [DW-1:0] B [MAXK][N];
  longint macc [N][N];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [N*ACC-1:0] act, input logic [N*ACC-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint op(input bit [DW-1:0] a, input bit sm);
    return sm ? longint'($signed(a)) : longint'(a);
  endfunction

  function automatic longint shape(input longint s, input bit sm);
`ifdef SYSTOLIC_GEN_SAT_EN
    longint v;
    if (sm) begin
      v = s >= (longint'(1) << (ACC - 1)) ? s - (longint'(1) << ACC) : s;
      if (v > (longint'(1) << (OW - 1)) - 1) v = (longint'(1) << (OW - 1)) - 1;
      if (v < -(longint'(1) << (OW - 1))) v = -(longint'(1) << (OW - 1));
      return v & MASK;
    end
    return s > (longint'(1) << OW) - 1 ? (longint'(1) << OW) - 1 : s;
`else
    return s;
`endif
  endfunction

  // scoreboard monitor: every accepted output row is checked against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL row_unexpected: got idx %0d row %h, nothing expected", out_row_idx, out_row);
      end else begin
        e = sbq.pop_front();
        if (out_row !== e.row || out_row_idx !== e.idx) begin
          failures++;
          $display("FAIL row: got idx %0d row %h expected idx %0d row %h", out_row_idx, out_row, e.idx, e.row);
        end
      end
    end
  end

  // mode 0: identity A with B[k][j]=N*k+j+1, mode 1: constant v, mode 2: random
  task automatic fill(input int mode, input int v);
    for (int kk = 0; kk < MAXK; kk++)
      for (int i = 0; i < N; i++) begin
        A[i][kk] = mode == 0 ? DW'(i == kk) : mode == 1 ? DW'(v) : DW'($urandom);
        B[kk][i] = mode == 0 ? DW'(N * kk + i + 1) : mode == 1 ? DW'(v) : DW'($urandom);
      end
  endtask

  task automatic load_beat(input int b);
    for (int i = 0; i < N; i++) begin
      d_col[i*DW +: DW] = A[i][b];
      w_row[i*DW +: DW] = B[b][i];
    end
  endtask

  task automatic garbage();
    d_col = $urandom;
    w_row = $urandom;
  endtask

  task automatic run_tile(input int k, input bit sm, input bit keep, input int gap, input bit stall, input bit rnd_ready);
    longint s;
    exp_t e, e0;
    int b, guard, n, m, dc0;
    bit v, hs;
    for (int i = 0; i < N; i++) begin
      e.idx = IW'(i);
      e.row = '0;
      for (int j = 0; j < N; j++) begin
        s = keep ? macc[i][j] : 0;
        for (int kk = 0; kk < k; kk++) s = (s + op(A[i][kk], sm) * op(B[kk][j], sm)) & MASK;
        macc[i][j] = s;
        e.row[j*ACC +: ACC] = ACC'(shape(s, sm));
      end
      if (i == 0) e0 = e;
      sbq.push_back(e);
    end
    out_ready = !stall;
    k_len = KW'(k);
    signed_mode = sm;
    acc_keep = keep;
    start = 1;
    chk("busy_before_start", busy, 0);
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", busy, 1);
    b = 0;
    guard = 0;
    while (b < k && guard < 5000) begin
      v = gap == 0 ? 1'b1 : gap == 1 ? (guard % 2 == 1) : 1'($urandom_range(0, 1));
      in_valid = v;
      if (v) load_beat(b); else garbage();
      hs = v && in_ready;
      @(posedge clk); #1;
      if (hs) b++;
      guard++;
    end
    chk("beats_accepted", b, k);
    in_valid = 1;
    garbage();
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_valid_latency", n, 2 * N);
    in_valid = 0;
    if (stall) begin
      repeat (10) begin
        @(posedge clk); #1;
        chk("stall_valid", out_valid, 1);
        chk("stall_idx", out_row_idx, 0);
        chk_row("stall_row", out_row, e0.row);
      end
      out_ready = 1;
    end
    dc0 = done_cnt;
    m = 0;
    while (!done && m < 200) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      m++;
    end
    chk("done_seen", done, 1);
    if (!rnd_ready) chk("drain_cycles", m, N);
    chk("idle_at_done", busy, 0);
    out_ready = 1;
    @(posedge clk); #1;
    chk("done_pulses", done_cnt - dc0, 1);
    chk("done_one_cycle", done, 0);
    chk("scoreboard_empty", sbq.size(), 0);
  endtask

  task automatic reset_mid_feed();
    fill(2, 0);
    k_len = KW'(8);
    signed_mode = 0;
    acc_keep = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1;
      load_beat(b);
      @(posedge clk); #1;
    end
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_out_valid", out_valid, 0);
    in_valid = 0;
    sbq.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) macc[i][j] = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) macc[i][j] = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", out_row_idx, 0);
    chk_row("rst_row", out_row, '0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    fill(0, 0);
    run_tile(4, 0, 0, 0, 0, 0);
    run_tile(4, 0, 0, 1, 0, 0);
    fill(1, 128);
    run_tile(256, 1, 0, 0, 0, 0);
    fill(1, 255);
    run_tile(256, 0, 0, 2, 0, 0);
    fill(1, 1);
    run_tile(4, 0, 0, 0, 0, 0);
    run_tile(4, 0, 1, 0, 0, 0);
    run_tile(4, 0, 0, 0, 0, 0);
    fill(0, 0);
    run_tile(4, 0, 0, 0, 1, 0);
    fill(2, 0);
    run_tile(0, 0, 1, 0, 0, 0);
    repeat (6) begin
      fill(2, 0);
      run_tile($urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 0, 1);
    end
    reset_mid_feed();
    fill(0, 0);
    run_tile(4, 0, 0, 0, 0, 0);
    fill(1, 128);
    run_tile(256, 1, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_gen.md
# systolic_gen

Parametrised output-stationary systolic matrix-multiply engine, the configurable successor of the fixed 32×32 array. It computes C = A·B for one ARRAY_SIZE×ARRAY_SIZE output tile over a runtime-selectable reduction length `k_len`. It has its own sequencing FSM, internal input skewing, valid/ready streaming on input and output, and a signed/unsigned mode. It also supports accumulating across tiles. It sits between the operand SRAM read path and the post-processing (quantise/activation) stage.

## Interface
- ARRAY_SIZE, 8, rows = columns of the PE grid.
- DATA_WIDTH, 8, operand width.
- MAX_K, 256, largest supported `k_len`.
- KW, $clog2(MAX_K+1), width of `k_len`.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(MAX_K), accumulator and result width.
- OUT_WIDTH, 2*DATA_WIDTH+5, width of the saturated result. Used only when `SYSTOLIC_GEN_SAT_EN` is defined.
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  begin a tile; sampled only in IDLE.
- k_len  in  KW  reduction length, latched at `start`.
- signed_mode  in  1  1 = operands are two's complement; latched at `start`.
- acc_keep  in  1  1 = keep accumulators from the previous tile; latched at `start`.
- busy  out  1  high whenever the FSM is not in IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when `in_valid & in_ready`.
- d_col  in  ARRAY_SIZE*DATA_WIDTH  A[i][k] for beat k; lane i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- w_row  in  ARRAY_SIZE*DATA_WIDTH  B[k][j] for beat k; lane j is packed the same way.
- out_valid  out  1  result row valid.
- out_ready  in  1  result row consumed when `out_valid & out_ready`.
- out_row_idx  out  $clog2(ARRAY_SIZE)  index i of the row currently presented.
- out_row  out  ARRAY_SIZE*ACC_WIDTH  C[i][j]; element j is at bits [j*ACC_WIDTH +: ACC_WIDTH].
- done  out  1  one-cycle pulse after the last row is accepted.

## Operation
- FSM states are IDLE → FEED → FLUSH → DRAIN → IDLE.
- IDLE:
  - `start` latches `k_len`, `signed_mode` and `acc_keep`.
  - All PE accumulators are cleared unless `acc_keep`=1.
  - Next state is FEED; if `k_len`=0 the FSM goes directly to FLUSH.
- FEED:
  - `in_ready`=1. Each handshake counts one beat.
  - The FSM moves to FLUSH on the handshake of beat `k_len`-1.
  - A cycle without a handshake injects a zero bubble on every lane, so gaps are allowed.
- Skew: data lane i is delayed i cycles and weight lane j is delayed j cycles before entering the grid.
- Data moves right and weights move down every cycle in FEED and FLUSH.
- PE(i,j) does acc += d·w each cycle. Bubbles contribute 0.
- FLUSH lasts exactly 2*ARRAY_SIZE-1 cycles of zero injection, then the FSM enters DRAIN.
- DRAIN:
  - Rows 0..ARRAY_SIZE-1 are presented in order.
  - `out_row_idx` advances on each handshake.
  - `done` pulses on the cycle after the last row is accepted, as the FSM returns to IDLE.
- Products are formed at 2*DATA_WIDTH bits: sign-extended when `signed_mode`=1, zero-extended otherwise. Accumulation wraps modulo 2^ACC_WIDTH.
- `start` is ignored while `busy`=1. Operand lanes are ignored outside FEED.

## Timing
- Reset values:
  - Outputs: `busy`, `in_ready`, `out_valid` and `done` are 0; `out_row_idx` and `out_row` are 0.
  - State: FSM in IDLE; all accumulators, skew registers and pipeline registers are 0.
- Reset mid-operation aborts the tile immediately. The next `start` behaves like the first one after power-up.
- `busy` rises on the cycle after `start`.
- `out_valid` first asserts exactly 2*ARRAY_SIZE cycles after the edge that accepted the last beat.
- With `out_ready` held at 1, rows stream one per cycle.
- `out_valid`, `out_row` and `out_row_idx` stay stable while `out_ready`=0.
- Throughput per tile is `k_len` + 2*ARRAY_SIZE + ARRAY_SIZE + 1 cycles with no stalls.

## Configuration
- `SYSTOLIC_GEN_SAT_EN` defined: each `out_row` element is saturated to the OUT_WIDTH range and then sign- or zero-extended to ACC_WIDTH.
  - The clamp range is signed or unsigned according to `signed_mode`.
  - Accumulators still wrap internally at ACC_WIDTH.
- Not defined: `out_row` is the raw accumulator and no clamp logic is built.

## Structure
- The package `systolic_pkg` holds:
  - the FSM state enum;
  - a `clog2` helper function;
  - the derived-width localparam formulas for KW, ACC_WIDTH and the row-index width.
- One sub-module, `systolic_pe`:
  - registered data and weight pass-through;
  - a multiply-accumulate with signed/unsigned select;
  - a synchronous clear and an enable.
- The top level contains the FSM, the beat and flush counters, the skew shift registers, the PE grid generate loop, and the output mux/register.

## Test plan
- ARRAY_SIZE=4, k_len=4, A = identity, B[k][j] = 4k+j+1 → rows 0..3 are {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}; `done` pulses once.
- Same stimulus with `in_valid` low on alternate cycles → identical rows; `out_valid` arrives 2*ARRAY_SIZE cycles after the last accepted beat.
- `signed_mode`=1, all operands -128, k_len=256 → every element is 4194304. `signed_mode`=0, all operands 255, k_len=256 → every element is 16646400.
- Two tiles of all-ones operands with k_len=4, the second with `acc_keep`=1 → second tile outputs 8 everywhere. A third tile with `acc_keep`=0 → 4.
- Hold `out_ready`=0 for 10 cycles at DRAIN entry → `out_valid`=1, row 0 and `out_row_idx`=0 stay stable; release → rows 1..3 follow on consecutive cycles.
- Assert `rst_n`=0 mid-FEED → `busy`, `in_ready` and `out_valid` drop asynchronously; the next identity test passes. With `SYSTOLIC_GEN_SAT_EN`, signed, all operands -128, k_len=256 → every element is 1048575.
